// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefRamDepth  = 256;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture
    } state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdW-1:0]     grant_idx_o,
    output logic               grant_valid_o
);

    int unsigned j;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        j             = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            j = (32'(last_grant_i) + k) % NUM_REQ;
            if (!grant_valid_o && req_i[j]) begin
                grant_o[j]    = 1'b1;
                grant_idx_o   = IdW'(j);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_REQ requesters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RAM_DEPTH  = DefRamDepth
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            ram_address,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    output logic                             ram_wdata_oe,
    input  logic [DATA_WIDTH-1:0]            ram_rdata,
    output logic                             ram_cs,
    output logic                             ram_we,
    output logic                             ram_oe,
    output logic                             busy
);

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         last_grant_q, last_grant_d;
    logic [IdW-1:0]         id_q, id_d;
    logic                   we_q, we_d;
    logic                   in_range_q, in_range_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IdW-1:0]         grant_idx;
    logic                   grant_valid;
    logic                   win_we;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_wdata;
    logic                   access;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IdW    (IdW)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_valid_o(grant_valid)
    );

    // Grant is one-hot, so OR-selecting the winner's fields is exact.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        in_range_d   = in_range_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d      = StAccess;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    we_d         = win_we;
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    in_range_d   = 32'(win_addr) < RAM_DEPTH;
                end
            end
            StAccess: begin
                state_d = we_q ? StIdle : StCapture;
            end
            StCapture: begin
                state_d     = StIdle;
                rsp_valid_d = NUM_REQ'(1) << id_q;
                rsp_rdata_d = in_range_q ? ram_rdata : '0;
                rsp_err_d   = !in_range_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_REQ - 1);
            id_q         <= '0;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            in_range_q   <= in_range_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Out-of-range accesses still spend the ACCESS cycle but leave the RAM untouched.
    always_comb begin
        access       = (state_q == StAccess) && in_range_q;
        ram_cs       = access;
        ram_we       = access && we_q;
        ram_oe       = access && !we_q;
        ram_wdata_oe = access && we_q;
        ram_wdata    = (access && we_q) ? wdata_q : '0;
        ram_address  = access ? addr_q : '0;
        req_ready    = (state_q == StIdle) ? grant : '0;
        busy         = state_q != StIdle;
        rsp_valid    = rsp_valid_q;
        rsp_rdata    = rsp_rdata_q;
        rsp_err      = rsp_err_q;
    end

endmodule
